// File: rtl/pgm_rd.sv
// Transmit end of the packet generator: replays the PGM_RAM template with a programmable gap, or forwards bypass traffic.
// Bypass latency 1; generated words appear 2 cycles after their read; downstream almost-full is honoured only before a head.
module pgm_rd #(
  parameter            PLATFORM   = "Xilinx",
  parameter int        GAP_CYCLES = 4,
  parameter logic [6:0] MAX_ADDR  = 7'd127
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1023:0] in_rd_phv,
  input  logic          in_rd_phv_wr,
  input  logic [133:0]  in_rd_data,
  input  logic          in_rd_data_wr,
  input  logic          in_rd_valid,
  input  logic          in_rd_valid_wr,
  output logic          out_rd_alf,
  input  logic          pgm_bypass_flag,
  input  logic          pgm_sent_start_flag,
  input  logic          pgm_sent_finish_flag,
  output logic          rd2ram_rd_en,
  output logic [6:0]    rd2ram_addr,
  input  logic [143:0]  ram2rd_rdata,
  output logic [1023:0] out_rd_phv,
  output logic          out_rd_phv_wr,
  output logic [133:0]  out_rd_data,
  output logic          out_rd_data_wr,
  output logic          out_rd_valid,
  output logic          out_rd_valid_wr,
  input  logic          in_rd_alf,
  output logic [31:0]   gen_pkt_cnt,
  output logic [31:0]   drop_pkt_cnt,
  output logic          gen_err
);

  typedef enum logic [1:0] {IDLE, BYPASS, GEN_RD, GEN_GAP} state_t;

  // The two-cycle read-to-output latency already contributes idle cycles to the gap.
  localparam logic [15:0] GAP_WAIT = (GAP_CYCLES > 2) ? 16'(GAP_CYCLES - 2) : 16'd0;
  localparam bit PLAT_XILINX = (PLATFORM == "Xilinx");

  state_t        state, state_nxt;
  logic          start_d, start_pend, start_edge, start_req, start_take;
  logic          rd_vld_d;
  logic [6:0]    addr_d;
  logic [15:0]   gap_cnt;
  logic          gap_done;
  logic          head_in, tail_in, fwd;
  logic          word_vld, word_head, word_last, gen_bad;
  logic [133:0]  word;
  logic          unused_bits;

  assign out_rd_alf  = in_rd_alf;
  assign unused_bits = ^{ram2rd_rdata[143:134], pgm_bypass_flag, PLAT_XILINX};

  assign head_in    = in_rd_data_wr && (in_rd_data[133:132] == 2'b01);
  assign tail_in    = in_rd_data_wr && (in_rd_data[133:132] == 2'b10);
  assign start_edge = pgm_sent_start_flag && !start_d;
  assign start_req  = start_edge || start_pend;
  assign word       = ram2rd_rdata[133:0];
  assign word_vld   = (state == GEN_RD) && rd_vld_d;
  assign word_head  = (word[133:132] == 2'b01);
  assign word_last  = (word[133:132] == 2'b10) || (addr_d == MAX_ADDR);
  assign gap_done   = (gap_cnt >= GAP_WAIT);
  assign fwd        = (state == BYPASS) || ((state == IDLE) && (state_nxt == BYPASS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    start_take = 1'b0;
    gen_bad    = 1'b0;
    case (state)
      IDLE: begin
        if (start_req && !in_rd_alf) begin
          state_nxt  = GEN_RD;
          start_take = 1'b1;
        end else if (head_in) begin
          state_nxt = BYPASS;
        end
      end
      BYPASS: if (tail_in) state_nxt = IDLE;
      GEN_RD: begin
        if (word_vld) begin
          if ((addr_d == 7'd0) && !word_head) begin
            gen_bad   = 1'b1;
            state_nxt = IDLE;
          end else if (word_last) begin
            state_nxt = GEN_GAP;
          end
        end
      end
      GEN_GAP: begin
        if (gap_done) begin
          if (pgm_sent_finish_flag) state_nxt = IDLE;
          else if (!in_rd_alf)      state_nxt = GEN_RD;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_d         <= 1'b0;
      start_pend      <= 1'b0;
      rd_vld_d        <= 1'b0;
      addr_d          <= 7'd0;
      gap_cnt         <= 16'd0;
      rd2ram_rd_en    <= 1'b0;
      rd2ram_addr     <= 7'd0;
      out_rd_phv      <= '0;
      out_rd_phv_wr   <= 1'b0;
      out_rd_data     <= '0;
      out_rd_data_wr  <= 1'b0;
      out_rd_valid    <= 1'b0;
      out_rd_valid_wr <= 1'b0;
      gen_pkt_cnt     <= 32'd0;
      drop_pkt_cnt    <= 32'd0;
      gen_err         <= 1'b0;
    end else begin
      start_d <= pgm_sent_start_flag;
      // A start seen while idle or forwarding is remembered until generation can begin.
      if (start_take)
        start_pend <= 1'b0;
      else if (start_edge && ((state == IDLE) || (state == BYPASS)))
        start_pend <= 1'b1;

      rd_vld_d <= rd2ram_rd_en;
      addr_d   <= rd2ram_addr;
      if (state_nxt == GEN_RD) begin
        rd2ram_rd_en <= 1'b1;
        rd2ram_addr  <= (state == GEN_RD) ? rd2ram_addr + 7'd1 : 7'd0;
      end else begin
        rd2ram_rd_en <= 1'b0;
      end

      if (state != GEN_GAP) gap_cnt <= 16'd0;
      else if (!gap_done)   gap_cnt <= gap_cnt + 16'd1;

      out_rd_phv_wr   <= 1'b0;
      out_rd_data_wr  <= 1'b0;
      out_rd_valid    <= 1'b0;
      out_rd_valid_wr <= 1'b0;
      if (fwd) begin
        out_rd_phv      <= in_rd_phv;
        out_rd_phv_wr   <= in_rd_phv_wr;
        out_rd_data     <= in_rd_data;
        out_rd_data_wr  <= in_rd_data_wr;
        out_rd_valid    <= in_rd_valid;
        out_rd_valid_wr <= in_rd_valid_wr;
      end else if (word_vld && !gen_bad) begin
        out_rd_data_wr <= 1'b1;
        out_rd_data    <= word_last ? {2'b10, word[131:0]} : word;
        if (addr_d == 7'd0) begin
          out_rd_phv_wr <= 1'b1;
          out_rd_phv    <= {992'b0, gen_pkt_cnt};
        end
        if (word_last) begin
          out_rd_valid    <= 1'b1;
          out_rd_valid_wr <= 1'b1;
          gen_pkt_cnt     <= gen_pkt_cnt + 32'd1;
        end
      end

      if (gen_bad) gen_err <= 1'b1;
      // Non-head words of a dropped packet fall through naturally: only a head opens BYPASS.
      if (head_in && ((state == GEN_RD) || (state == GEN_GAP) || start_take))
        drop_pkt_cnt <= drop_pkt_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_pgm_rd.sv
// Bench for pgm_rd: bypass vector table, template generation, almost-full, bad template, forced tail, mid-packet reset.
module tb_pgm_rd;

  logic          clk = 1'b0;
  logic          rst;
  logic [1023:0] in_rd_phv;
  logic          in_rd_phv_wr;
  logic [133:0]  in_rd_data;
  logic          in_rd_data_wr;
  logic          in_rd_valid;
  logic          in_rd_valid_wr;
  logic          out_rd_alf;
  logic          pgm_bypass_flag;
  logic          pgm_sent_start_flag;
  logic          pgm_sent_finish_flag;
  logic          rd2ram_rd_en;
  logic [6:0]    rd2ram_addr;
  logic [143:0]  ram2rd_rdata;
  logic [1023:0] out_rd_phv;
  logic          out_rd_phv_wr;
  logic [133:0]  out_rd_data;
  logic          out_rd_data_wr;
  logic          out_rd_valid;
  logic          out_rd_valid_wr;
  logic          in_rd_alf;
  logic [31:0]   gen_pkt_cnt;
  logic [31:0]   drop_pkt_cnt;
  logic          gen_err;

  pgm_rd dut (
    .clk(clk), .rst(rst),
    .in_rd_phv(in_rd_phv), .in_rd_phv_wr(in_rd_phv_wr),
    .in_rd_data(in_rd_data), .in_rd_data_wr(in_rd_data_wr),
    .in_rd_valid(in_rd_valid), .in_rd_valid_wr(in_rd_valid_wr),
    .out_rd_alf(out_rd_alf), .pgm_bypass_flag(pgm_bypass_flag),
    .pgm_sent_start_flag(pgm_sent_start_flag), .pgm_sent_finish_flag(pgm_sent_finish_flag),
    .rd2ram_rd_en(rd2ram_rd_en), .rd2ram_addr(rd2ram_addr), .ram2rd_rdata(ram2rd_rdata),
    .out_rd_phv(out_rd_phv), .out_rd_phv_wr(out_rd_phv_wr),
    .out_rd_data(out_rd_data), .out_rd_data_wr(out_rd_data_wr),
    .out_rd_valid(out_rd_valid), .out_rd_valid_wr(out_rd_valid_wr),
    .in_rd_alf(in_rd_alf), .gen_pkt_cnt(gen_pkt_cnt), .drop_pkt_cnt(drop_pkt_cnt),
    .gen_err(gen_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [133:0]  data;
    logic          phv_wr;
    logic [1023:0] phv;
    logic          last;
  } exp_t;

  typedef struct {
    logic          d_wr;
    logic [133:0]  d;
    logic          p_wr;
    logic [1023:0] p;
    logic          v;
    logic          x_dwr;
    logic          x_pwr;
    logic          x_vwr;
  } vec_t;

  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  int            last_tail = 0;
  exp_t          exp_q[$];
  int            gaps[$];
  logic [143:0]  mem [128];
  vec_t          tbl [7];
  logic [1023:0] phv_a;
  logic [6:0]    addr_s;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (rd2ram_rd_en) ram2rd_rdata <= mem[rd2ram_addr];

  task automatic chk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every emitted data word must match the oldest expected word.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_rd_data_wr) begin
      if (exp_q.size() == 0) begin
        chk("sb_extra_word", {1023'b0, out_rd_data_wr}, 1024'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_word", {889'b0, out_rd_data, out_rd_phv_wr, out_rd_valid, out_rd_valid_wr},
            {889'b0, e.data, e.phv_wr, e.last, e.last});
        if (e.phv_wr) begin
          chk("sb_phv", out_rd_phv, e.phv);
          gaps.push_back(cyc - last_tail - 1);
        end
        if (e.last) last_tail = cyc;
      end
    end
  end

  function automatic logic [143:0] mk(input logic [1:0] tag, input logic [31:0] v);
    return {10'h2a5, tag, 100'h0, v};
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_pkt(input logic [31:0] num);
    exp_t e;
    for (int a = 0; a < 128; a++) begin
      e.data   = mem[a][133:0];
      e.last   = (mem[a][133:132] == 2'b10) || (a == 127);
      if (e.last) e.data[133:132] = 2'b10;
      e.phv_wr = (a == 0);
      e.phv    = {992'b0, num};
      exp_q.push_back(e);
      if (e.last) break;
    end
  endtask

  task automatic wait_cnt(input logic [31:0] v, input int budget, input string name);
    int n = 0;
    while (gen_pkt_cnt != v && n < budget) begin
      tick();
      n++;
    end
    chk(name, {992'b0, gen_pkt_cnt}, {992'b0, v});
  endtask

  task automatic wait_rd(input int budget, input string name);
    int n = 0;
    while (!rd2ram_rd_en && n < budget) begin
      tick();
      n++;
    end
    chk(name, {1023'b0, rd2ram_rd_en}, 1024'd1);
  endtask

  task automatic load_template();
    mem[0] = mk(2'b01, 32'hA000_0000);
    mem[1] = mk(2'b11, 32'hA000_0001);
    mem[2] = mk(2'b11, 32'hA000_0002);
    mem[3] = mk(2'b10, 32'hA000_0003);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1;
    in_rd_phv = '0; in_rd_phv_wr = 1'b0; in_rd_data = '0; in_rd_data_wr = 1'b0;
    in_rd_valid = 1'b0; in_rd_valid_wr = 1'b0; pgm_bypass_flag = 1'b0;
    pgm_sent_start_flag = 1'b0; pgm_sent_finish_flag = 1'b0; in_rd_alf = 1'b0;
    for (int a = 0; a < 128; a++) mem[a] = mk(2'b11, 32'hB000_0000 + a);
    load_template();
    phv_a = {32'hDEAD_BEEF, 960'h0, 32'h0000_0011};

    tbl[0] = '{1'b1, {2'b01, 132'h1111_0001}, 1'b1, phv_a, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{1'b1, {2'b11, 132'h1111_0002}, 1'b0, phv_a, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 134'h0,                  1'b0, phv_a, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b1, {2'b10, 132'h1111_0003}, 1'b0, phv_a, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 134'h0,                  1'b0, phv_a, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b1, {2'b11, 132'h1111_0005}, 1'b0, phv_a, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 134'h0,                  1'b0, phv_a, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset state
    tick(2);
    chk("rst_strobes", {1019'b0, out_rd_data_wr, out_rd_phv_wr, out_rd_valid, out_rd_valid_wr, rd2ram_rd_en}, 1024'd0);
    chk("rst_data", {890'b0, out_rd_data}, 1024'd0);
    chk("rst_cnts", {959'b0, gen_pkt_cnt, drop_pkt_cnt, gen_err}, 1024'd0);
    rst = 1'b0;
    tick();

    // 1: bypass vectors
    for (int i = 0; i < 7; i++) begin
      in_rd_data_wr = tbl[i].d_wr; in_rd_data = tbl[i].d;
      in_rd_phv_wr = tbl[i].p_wr; in_rd_phv = tbl[i].p;
      in_rd_valid = tbl[i].v; in_rd_valid_wr = tbl[i].v;
      pgm_bypass_flag = tbl[i].d_wr;
      if (tbl[i].x_dwr) exp_q.push_back('{tbl[i].d, tbl[i].p_wr, tbl[i].p, tbl[i].v});
      tick();
      chk($sformatf("tbl%0d_strobes", i), {1021'b0, out_rd_data_wr, out_rd_phv_wr, out_rd_valid_wr},
          {1021'b0, tbl[i].x_dwr, tbl[i].x_pwr, tbl[i].x_vwr});
    end
    in_rd_data_wr = 1'b0; in_rd_phv_wr = 1'b0; in_rd_valid = 1'b0; in_rd_valid_wr = 1'b0;
    pgm_bypass_flag = 1'b0;
    tick(2);
    chk("bypass_cnts", {960'b0, gen_pkt_cnt, drop_pkt_cnt}, 1024'd0);

    // 2: two generated packets, finish raised during the second
    push_pkt(32'd0);
    push_pkt(32'd1);
    pgm_sent_start_flag = 1'b1;
    wait_cnt(32'd1, 100, "gen1_done");
    gaps.delete();
    wait_rd(20, "gen2_rd_start");
    pgm_sent_finish_flag = 1'b1;
    wait_cnt(32'd2, 100, "gen2_done");
    tick(20);
    chk("gen_q_empty", 1024'(exp_q.size()), 1024'd0);
    chk("gen_gap_len", 1024'(gaps.size() > 0 ? gaps[0] : -1), 1024'd4);
    chk("gen_stopped", {992'b0, gen_pkt_cnt}, 1024'd2);
    pgm_sent_start_flag = 1'b0;
    pgm_sent_finish_flag = 1'b0;
    tick(2);

    // 3: almost-full during packet 1 delays the next head only
    push_pkt(32'd2);
    push_pkt(32'd3);
    pgm_sent_start_flag = 1'b1;
    n = 0;
    while (!out_rd_data_wr && n < 20) begin tick(); n++; end
    chk("alf_first_word", {1023'b0, out_rd_data_wr}, 1024'd1);
    in_rd_alf = 1'b1;
    chk("alf_passthru", {1023'b0, out_rd_alf}, 1024'd1);
    wait_cnt(32'd3, 100, "alf_pkt1_done");
    gaps.delete();
    tick(5);
    chk("alf_hold_rd", {1023'b0, rd2ram_rd_en}, 1024'd0);
    tick(5);
    in_rd_alf = 1'b0;
    wait_rd(20, "alf_resume_rd");
    pgm_sent_finish_flag = 1'b1;
    wait_cnt(32'd4, 100, "alf_pkt2_done");
    tick(20);
    chk("alf_gap_len", 1024'(gaps.size() > 0 ? gaps[0] : -1), 1024'd12);
    chk("alf_q_empty", 1024'(exp_q.size()), 1024'd0);
    pgm_sent_start_flag = 1'b0;
    pgm_sent_finish_flag = 1'b0;
    tick(2);

    // 4: template word 0 is not a head
    mem[0] = mk(2'b11, 32'hBAD0_0000);
    pgm_sent_start_flag = 1'b1;
    tick(8);
    chk("bad_err", {1023'b0, gen_err}, 1024'd1);
    chk("bad_cnt", {992'b0, gen_pkt_cnt}, 1024'd4);
    chk("bad_idle_rd", {1023'b0, rd2ram_rd_en}, 1024'd0);
    pgm_sent_start_flag = 1'b0;
    tick(2);

    // 5: no tail in RAM forces a 128-word packet; a bypass packet arrives meanwhile
    for (int a = 0; a < 128; a++) mem[a] = mk(2'b11, 32'hC000_0000 + a);
    mem[0] = mk(2'b01, 32'hC000_0000);
    push_pkt(32'd4);
    pgm_sent_finish_flag = 1'b1;
    pgm_sent_start_flag = 1'b1;
    tick(10);
    addr_s = rd2ram_addr;
    tick();
    chk("addr_incr", {1017'b0, rd2ram_addr}, {1017'b0, addr_s + 7'd1});
    in_rd_data_wr = 1'b1; in_rd_data = {2'b01, 132'hD1}; in_rd_phv_wr = 1'b1;
    tick();
    in_rd_data = {2'b11, 132'hD2}; in_rd_phv_wr = 1'b0;
    tick();
    in_rd_data = {2'b10, 132'hD3}; in_rd_valid = 1'b1; in_rd_valid_wr = 1'b1;
    tick();
    in_rd_data_wr = 1'b0; in_rd_valid = 1'b0; in_rd_valid_wr = 1'b0;
    wait_cnt(32'd5, 400, "long_done");
    tick(20);
    chk("long_q_empty", 1024'(exp_q.size()), 1024'd0);
    chk("drop_cnt", {992'b0, drop_pkt_cnt}, 1024'd1);
    pgm_sent_start_flag = 1'b0;
    tick(2);

    // 6: reset mid-packet, then regenerate from address 0
    push_pkt(32'd5);
    pgm_sent_start_flag = 1'b1;
    tick(25);
    chk("pre_rst_active", {1023'b0, rd2ram_rd_en}, 1024'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_strobes", {1019'b0, out_rd_data_wr, out_rd_phv_wr, out_rd_valid, out_rd_valid_wr, rd2ram_rd_en}, 1024'd0);
    chk("mid_rst_data", {890'b0, out_rd_data}, 1024'd0);
    chk("mid_rst_cnts", {959'b0, gen_pkt_cnt, drop_pkt_cnt, gen_err}, 1024'd0);
    exp_q.delete();
    pgm_sent_start_flag = 1'b0;
    tick(2);
    load_template();
    rst = 1'b0;
    tick(2);
    push_pkt(32'd0);
    pgm_sent_start_flag = 1'b1;
    wait_rd(10, "post_rst_rd");
    chk("post_rst_addr0", {1017'b0, rd2ram_addr}, 1024'd0);
    wait_cnt(32'd1, 100, "post_rst_done");
    tick(15);
    chk("post_rst_q_empty", 1024'(exp_q.size()), 1024'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
